tmds_channel_rx: RTL and testbench
==================================

TMDS_CHANNEL_RX -- requirements
Module: tmds_channel_rx

Interface
REQ-001 SHALL have parameter LOCK_RUN, default 8: consecutive control tokens required to declare lock.
REQ-002 SHALL have parameter TIMEOUT, default 1023: cycles without a control token before slip (SEARCH) or unlock (LOCKED).
REQ-003 SHALL have port clk  in  1  pixel clock; one 10-bit word per cycle; sole clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port tmds_in  in  10  deserialized channel word, bit 0 earliest on wire, arbitrary word alignment.
REQ-006 SHALL have port vd  out  8  decoded video data.
REQ-007 SHALL have port cd  out  2  decoded control bits {c1,c0}.
REQ-008 SHALL have port vde  out  1  high when the current symbol is a data symbol.
REQ-009 SHALL have port locked  out  1  word alignment established.
REQ-010 SHALL have port bit_offset  out  4  current alignment offset, 0..9.

Function
REQ-011 SHALL register tmds_in into raw_q each cycle and form a 20-bit window {tmds_in, raw_q}; aligned word = window[bit_offset+9 : bit_offset].
REQ-012 SHALL register the aligned word (stage 1), then decode it into registered outputs (stage 2); a word sampled at edge k at offset 0 appears on outputs after edge k+2.
REQ-013 SHALL recognise control tokens: 1101010100->cd 00, 0010101011->01, 0101010100->10, 1010101011->11; token gives vde=0 and vd=0, and cd updated.
REQ-014 SHALL decode any non-token word q as data: q'=q[9] ? ~q[7:0] : q[7:0]; d0=q'0; di = q'i ^ q'(i-1) if q[8]=1, else ~(q'i ^ q'(i-1)); vde=1, cd holds its last value.
REQ-015 SHALL implement an FSM with states SEARCH and LOCKED; locked=1 only in LOCKED.
REQ-016 In SEARCH, SHALL increment run counter on each aligned token and clear it on each non-token; SHALL go LOCKED when run reaches LOCK_RUN.
REQ-017 In SEARCH, SHALL count cycles since last token; on reaching TIMEOUT, bit_offset SHALL increment (9 wraps to 0), and the run and timeout counters SHALL clear.
REQ-018 If lock condition and timeout occur in the same cycle, lock SHALL win, with no slip.
REQ-019 In LOCKED, any token SHALL clear the timeout counter; on reaching TIMEOUT, the FSM SHALL return to SEARCH, increment bit_offset (wrap 9->0), and clear counters.
REQ-020 While not LOCKED, outputs SHALL be forced to vd=0, cd=00, vde=0 (decoder result discarded).
REQ-021 bit_offset SHALL be stable in LOCKED; an offset change SHALL restart token counting.
REQ-022 Counter widths SHALL hold TIMEOUT and LOCK_RUN without overflow; comparisons SHALL be unsigned.

Reset
REQ-023 Asserting rst_n low SHALL immediately clear raw_q, stage registers, counters, bit_offset=0, state=SEARCH, vd=0, cd=00, vde=0, locked=0, including mid-lock.
REQ-024 Release of rst_n SHALL be synchronised internally to clk before it affects the FSM.

Structure
REQ-025 The four control-token constants, the FSM state enumeration and the default LOCK_RUN/TIMEOUT values SHALL live in shared package tmds_pkg, which the encoder side also uses.
REQ-026 Symbol decoding (REQ-013/014) SHALL be a combinational sub-module tmds_symbol_decode; alignment, FSM and registers stay in tmds_channel_rx.

Verification
REQ-027 Aligned stream of 8 x 1101010100 from reset -> locked=1 after 8th token reaches stage 1; cd=00, vde=0, bit_offset=0.
REQ-028 Locked, then words 0100000000 and 1011111111 -> vd=0x00 then vd=0xFE, vde=1, each 2 cycles after input; cd unchanged.
REQ-029 Repeating line (160 tokens 1010101011 + 640 data words) shifted by 3 bits -> bit_offset steps 0..3 at TIMEOUT intervals, locks at 3, cd=11 during blanking.
REQ-030 Locked, then TIMEOUT consecutive data words -> locked drops, bit_offset increments by 1, outputs forced to zero next cycle; offset 9 case wraps to 0.
REQ-031 rst_n pulsed low mid-line while locked -> all outputs 0 and bit_offset=0 asynchronously; relock after LOCK_RUN tokens following release.
REQ-032 In SEARCH, 7 tokens, 1 data word, then 8 tokens -> lock only after the second run's 8th token.

Source files
------------

// File: rtl/tmds_pkg.sv
// ---------------------------------------------------------------------------
// tmds_pkg
//   Definitions shared by the TMDS encoder and receiver sides of a channel:
//   - the four 10-bit control tokens (written bit 9 .. bit 0, bit 0 is the
//     first bit on the wire)
//   - the receiver alignment FSM state encoding
//   - default lock / timeout thresholds for the receiver
//   - a helper that advances a bit alignment offset with wrap 9 -> 0
// ---------------------------------------------------------------------------
package tmds_pkg;

    localparam int SYM_W = 10;

    // Control tokens carrying {c1,c0}
    localparam logic [SYM_W-1:0] TOK_C00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOK_C01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOK_C10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOK_C11 = 10'b1010101011;

    // Consecutive aligned control tokens needed before alignment is trusted
    localparam int LOCK_RUN_DEFAULT = 8;
    // Cycles without a control token before the alignment is abandoned
    localparam int TIMEOUT_DEFAULT  = 1023;

    // Receiver alignment FSM
    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } rx_state_t;

    // Next bit offset to try; any out-of-range value also returns to 0.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off >= 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// ---------------------------------------------------------------------------
// tmds_symbol_decode
//   Purely combinational decode of one aligned 10-bit TMDS symbol.
//
// Ports
//   sym      in  10  aligned symbol, bit 0 earliest on the wire
//   is_ctrl  out 1   symbol is one of the four control tokens
//   ctrl     out 2   {c1,c0} carried by the token (00 when not a token)
//   data     out 8   video data decoded from the symbol (only meaningful
//                    when is_ctrl is low)
// ---------------------------------------------------------------------------
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic             is_ctrl,
    output logic [1:0]       ctrl,
    output logic [7:0]       data
);

    logic [7:0] q_m;

    // Control token match
    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (sym)
            TOK_C00: ctrl = 2'b00;
            TOK_C01: ctrl = 2'b01;
            TOK_C10: ctrl = 2'b10;
            TOK_C11: ctrl = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    // Data decode: bit 9 undoes the DC-balance inversion, bit 8 selects
    // whether the transition-minimising chain used XOR or XNOR.
    always_comb begin
        q_m     = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = 8'h00;
        data[0] = q_m[0];
        for (int i = 1; i < 8; i++) begin
            if (sym[8]) begin
                data[i] = q_m[i] ^ q_m[i-1];
            end else begin
                data[i] = ~(q_m[i] ^ q_m[i-1]);
            end
        end
    end

endmodule

// File: rtl/tmds_channel_rx.sv
// ---------------------------------------------------------------------------
// tmds_channel_rx
//   One TMDS receive channel: finds the 10-bit word boundary in a
//   deserialised stream of arbitrary alignment, then decodes each symbol
//   into video data or control bits.
//
//   Alignment search: the FSM counts control tokens seen at the current bit
//   offset. LOCK_RUN consecutive tokens declare lock. TIMEOUT cycles without
//   a token slide the offset by one bit (SEARCH) or drop lock and slide
//   (LOCKED). Outputs are forced to zero whenever the channel is not locked.
//
//   Pipeline: tmds_in -> raw_q (one word history) -> aligned select ->
//   stage1_q -> decode -> registered outputs. A word presented at edge k
//   at offset 0 reaches the outputs after edge k+2.
//
// Ports
//   clk         in  1   pixel clock, one word per cycle
//   rst_n       in  1   asynchronous active-low reset (release synchronised)
//   tmds_in     in  10  deserialised word, bit 0 earliest on the wire
//   vd          out 8   decoded video data
//   cd          out 2   decoded control bits {c1,c0}
//   vde         out 1   current symbol is a data symbol
//   locked      out 1   word alignment established (FSM in LOCKED)
//   bit_offset  out 4   current alignment offset 0..9
// ---------------------------------------------------------------------------
module tmds_channel_rx
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN = LOCK_RUN_DEFAULT,
    parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] tmds_in,
    output logic [7:0]       vd,
    output logic [1:0]       cd,
    output logic             vde,
    output logic             locked,
    output logic [3:0]       bit_offset
);

    // Counters sized to hold their full threshold value
    localparam int RUN_W = $clog2(LOCK_RUN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // Counters are compared against threshold-1 so that the cycle in which
    // the threshold is reached is the cycle that acts on it.
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_RUN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // -----------------------------------------------------------------------
    // Reset: assert asynchronously, release two clock edges later
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // Word alignment
    // -----------------------------------------------------------------------
    logic [SYM_W-1:0]   raw_q;
    logic [2*SYM_W-1:0] window;
    logic [SYM_W-1:0]   aligned;
    logic [SYM_W-1:0]   stage1_q;
    logic [3:0]         off_q;

    // raw_q holds the earlier word, so it sits in the low half; offset k
    // starts the symbol k bits later on the wire.
    assign window  = {tmds_in, raw_q};
    assign aligned = SYM_W'(window >> off_q);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            raw_q    <= '0;
            stage1_q <= '0;
        end else begin
            raw_q    <= tmds_in;
            stage1_q <= aligned;
        end
    end

    // -----------------------------------------------------------------------
    // Symbol decode of stage 1
    // -----------------------------------------------------------------------
    logic       dec_is_ctrl;
    logic [1:0] dec_ctrl;
    logic [7:0] dec_data;

    tmds_symbol_decode u_decode (
        .sym     (stage1_q),
        .is_ctrl (dec_is_ctrl),
        .ctrl    (dec_ctrl),
        .data    (dec_data)
    );

    // -----------------------------------------------------------------------
    // Alignment FSM
    // -----------------------------------------------------------------------
    rx_state_t        state_q, state_n;
    logic [RUN_W-1:0] run_q, run_n;
    logic [TMO_W-1:0] tmo_q, tmo_n;
    logic [3:0]       off_n;
    logic             slip;
    logic             slip_q;
    logic             tok_seen;

    // The word in stage1 right after an offset change was cut at the old
    // offset; it must not count towards the new offset's token run.
    assign tok_seen = dec_is_ctrl & ~slip_q;

    // State register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_SEARCH;
            run_q   <= '0;
            tmo_q   <= '0;
            off_q   <= 4'd0;
            slip_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            run_q   <= run_n;
            tmo_q   <= tmo_n;
            off_q   <= off_n;
            slip_q  <= slip;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        run_n   = run_q;
        tmo_n   = tmo_q;
        off_n   = off_q;
        slip    = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                // A token always takes precedence over the timeout, so a
                // lock completing on the timeout cycle never slips.
                if (tok_seen) begin
                    tmo_n = '0;
                    if (run_q >= RUN_LAST) begin
                        state_n = ST_LOCKED;
                        run_n   = '0;
                    end else begin
                        run_n = run_q + RUN_W'(1);
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    slip  = 1'b1;
                    off_n = next_offset(off_q);
                    run_n = '0;
                    tmo_n = '0;
                end else begin
                    run_n = '0;
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end
            ST_LOCKED: begin
                // Offset is frozen here; only a token drought moves it.
                if (tok_seen) begin
                    tmo_n = '0;
                end else if (tmo_q >= TMO_LAST) begin
                    state_n = ST_SEARCH;
                    slip    = 1'b1;
                    off_n   = next_offset(off_q);
                    run_n   = '0;
                    tmo_n   = '0;
                end else begin
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_n = ST_SEARCH;
                run_n   = '0;
                tmo_n   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        locked     = (state_q == ST_LOCKED);
        bit_offset = off_q;
    end

    // -----------------------------------------------------------------------
    // Stage 2: registered decoder outputs
    // -----------------------------------------------------------------------
    logic [7:0] vd_q;
    logic [1:0] cd_q;
    logic       vde_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vd_q  <= 8'h00;
            cd_q  <= 2'b00;
            vde_q <= 1'b0;
        end else if (state_q != ST_LOCKED) begin
            vd_q  <= 8'h00;
            cd_q  <= 2'b00;
            vde_q <= 1'b0;
        end else if (dec_is_ctrl) begin
            vd_q  <= 8'h00;
            cd_q  <= dec_ctrl;
            vde_q <= 1'b0;
        end else begin
            // Data symbol: control bits keep their last token value
            vd_q  <= dec_data;
            vde_q <= 1'b1;
        end
    end

    assign vd  = vd_q;
    assign cd  = cd_q;
    assign vde = vde_q;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// ---------------------------------------------------------------------------
// tb_tmds_channel_rx
//   Directed bench for tmds_channel_rx with default parameters.
//   Outputs are packed as {locked, bit_offset, vde, cd, vd} (16 bits).
// ---------------------------------------------------------------------------
module tb_tmds_channel_rx;

    localparam int TMO   = 1023;
    localparam int RUN   = 8;
    localparam int OUT_W = 16;

    // Tokens and data words, written bit 9 .. bit 0
    localparam logic [9:0] T00    = 10'b1101010100;
    localparam logic [9:0] T01    = 10'b0010101011;
    localparam logic [9:0] T10    = 10'b0101010100;
    localparam logic [9:0] T11    = 10'b1010101011;
    localparam logic [9:0] D_ZERO = 10'b0100000000;  // decodes to 0x00
    localparam logic [9:0] D_FE   = 10'b1011111111;  // decodes to 0xFE
    localparam logic [9:0] D_D0   = 10'b0110110000;  // decodes to 0xD0

    logic       clk;
    logic       rst_n;
    logic [9:0] tmds_in;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] bit_offset;

    int n_checks;
    int n_pass;

    logic [9:0] prev_word;
    int         shift;

    typedef struct {
        bit               rst_before;
        logic [9:0]       word;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t             tbl[$];
    logic [OUT_W-1:0] exp_q[$];

    tmds_channel_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tmds_in    (tmds_in),
        .vd         (vd),
        .cd         (cd),
        .vde        (vde),
        .locked     (locked),
        .bit_offset (bit_offset)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [OUT_W-1:0] outs();
        return {locked, bit_offset, vde, cd, vd};
    endfunction

    function automatic logic [OUT_W-1:0] mk(input bit l, input int off, input bit v,
                                            input logic [1:0] c, input logic [7:0] d);
        return {l, 4'(off), v, c, d};
    endfunction

    function automatic logic [9:0] line_word(input int p);
        return ((p % 800) < 160) ? T11 : D_FE;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents one true-stream word delayed on the wire by 'shift' bits.
    task automatic send(input logic [9:0] word);
        logic [19:0] pair;
        pair      = {word, prev_word};
        tmds_in   = 10'(pair >> (10 - shift));
        prev_word = word;
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and let the two release-synchroniser edges pass.
    task automatic do_reset();
        rst_n     = 1'b0;
        tmds_in   = '0;
        prev_word = '0;
        shift     = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(10'd0);
        send(10'd0);
    endtask

    task automatic add(input bit r, input logic [9:0] w, input logic [OUT_W-1:0] e);
        vec_t v;
        v.rst_before = r;
        v.word       = w;
        v.exp        = e;
        tbl.push_back(v);
    endtask

    // Locked with last token just sent; feed data until lock is lost.
    task automatic run_timeout(input string tag, input int off_before, input int off_after);
        for (int m = 1; m <= TMO + 3; m++) begin
            send(D_FE);
            if (m == TMO + 1) begin
                check({tag, "_still_locked"}, {locked, bit_offset}, {1'b1, 4'(off_before)});
            end
            if (m == TMO + 2) begin
                check({tag, "_unlock"}, outs(), mk(1'b0, off_after, 1'b1, 2'b00, 8'hFE));
            end
            if (m == TMO + 3) begin
                check({tag, "_forced_zero"}, outs(), mk(1'b0, off_after, 1'b0, 2'b00, 8'h00));
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int t, p, nchg, last_off, bad, nvde, k;
        logic [OUT_W-1:0] got, exp;

        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b1;
        tmds_in   = '0;
        prev_word = '0;
        shift     = 0;

        // Reset state
        do_reset();
        check("reset_state", outs(), 16'h0000);

        // Segment A: aligned lock on T00, then data / token decode
        for (int i = 1; i <= 9; i++) add(i == 1, T00, mk(0, 0, 0, 2'b00, 8'h00));
        add(0, T00,    mk(1, 0, 0, 2'b00, 8'h00));
        add(0, D_ZERO, mk(1, 0, 0, 2'b00, 8'h00));
        add(0, D_FE,   mk(1, 0, 0, 2'b00, 8'h00));
        add(0, T10,    mk(1, 0, 1, 2'b00, 8'h00));  // D_ZERO out
        add(0, D_D0,   mk(1, 0, 1, 2'b00, 8'hFE));  // D_FE out
        add(0, T00,    mk(1, 0, 0, 2'b10, 8'h00));  // T10 out
        add(0, T01,    mk(1, 0, 1, 2'b10, 8'hD0));  // D_D0 out, cd held
        add(0, T11,    mk(1, 0, 0, 2'b00, 8'h00));  // T00 out
        add(0, D_FE,   mk(1, 0, 0, 2'b01, 8'h00));  // T01 out
        add(0, T00,    mk(1, 0, 0, 2'b11, 8'h00));  // T11 out
        add(0, T00,    mk(1, 0, 1, 2'b11, 8'hFE));  // D_FE out, cd held
        add(0, T00,    mk(1, 0, 0, 2'b00, 8'h00));
        // Segment B: 7 tokens, a data word, then a fresh run of tokens
        for (int i = 1; i <= 7; i++) add(i == 1, T00, mk(0, 0, 0, 2'b00, 8'h00));
        add(0, D_ZERO, mk(0, 0, 0, 2'b00, 8'h00));
        for (int i = 9; i <= 17; i++) add(0, T00, mk(0, 0, 0, 2'b00, 8'h00));
        add(0, T00, mk(1, 0, 0, 2'b00, 8'h00));
        add(0, T00, mk(1, 0, 0, 2'b00, 8'h00));

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            send(tbl[i].word);
            exp_q.push_back(tbl[i].exp);
            got = outs();
            exp = exp_q.pop_front();
            check($sformatf("vec%0d", i), got, exp);
        end

        // Timeout while locked at offset 0 -> offset 1
        do_reset();
        repeat (10) send(T00);
        check("tmo_pre_locked", locked, 1);
        run_timeout("tmo0", 0, 1);

        // Line shifted by 3 bits: slips 0..3 at TIMEOUT intervals, then lock
        do_reset();
        shift    = 3;
        p        = 0;
        t        = 0;
        nchg     = 0;
        last_off = 0;
        while (!locked && t < 6000) begin
            send(line_word(p));
            p++;
            t++;
            if (int'(bit_offset) != last_off) begin
                nchg++;
                check($sformatf("slip_value%0d", nchg), bit_offset, nchg);
                check($sformatf("slip_time%0d", nchg), t, nchg * TMO);
                last_off = int'(bit_offset);
            end
        end
        check("line_locked", locked, 1);
        check("line_offset", bit_offset, 3);
        check("line_slip_count", nchg, 3);
        send(line_word(p));
        p++;
        bad  = 0;
        nvde = 0;
        for (int i = 0; i < 800; i++) begin
            send(line_word(p));
            p++;
            if (!locked || bit_offset != 4'd3 || cd != 2'b11) begin
                bad++;
            end else if (vde) begin
                nvde++;
                if (vd != 8'hFE) bad++;
            end else if (vd != 8'h00) begin
                bad++;
            end
        end
        check("line_bad_cycles", bad, 0);
        check("line_vde_count", nvde, 640);

        // Asynchronous reset mid-line while locked, then relock
        check("pre_reset_locked", {locked, bit_offset}, {1'b1, 4'd3});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", outs(), 16'h0000);
        @(posedge clk);
        #1;
        check("held_reset_outs", outs(), 16'h0000);
        rst_n     = 1'b1;
        shift     = 0;
        prev_word = '0;
        k         = 0;
        while (!locked && k < 40) begin
            send(T00);
            k++;
        end
        check("relock_sends", k, RUN + 4);
        check("relock_offset", bit_offset, 0);

        // Lock at offset 9, then timeout wraps the offset to 0
        do_reset();
        shift = 9;
        t     = 0;
        while (!locked && t < 12000) begin
            send(T00);
            t++;
        end
        check("wrap_pre_locked", {locked, bit_offset}, {1'b1, 4'd9});
        run_timeout("tmo9", 9, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
